// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 64-bit data memory.
// Sub-doubleword stores are sequenced as read-modify-write.
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [15:0] mask,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [1:0]  wack,
  output logic [1:0]  err,
  output logic [63:0] rdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic [63:0] mem_a,
  output logic [63:0] mem_wd,
  input  logic [63:0] mem_rd
);
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR} state_t;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [60:0] idx;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } req_t;

  state_t      state;
  req_t        cur;
  logic        last_owner;
  logic [63:0] merge_q;
  logic        win, err_q, full, empty, partial;
  logic [63:0] bmask;
  logic        unused_lsb;

  assign unused_lsb = ^{addr0[2:0], addr1[2:0]};

  // On a tie the requester that did not own the last access wins.
  assign win = (req == 2'b11) ? ~last_owner : req[1];
  assign gnt = (rst_n && state == IDLE && |req) ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign err_q   = (cur.idx >= 61'(DEPTH));
  assign full    = (cur.mask == 8'hFF);
  assign empty   = (cur.mask == 8'h00);
  assign partial = !full && !empty;

  for (genvar k = 0; k < 8; k++) begin : g_bmask
    assign bmask[8*k +: 8] = {8{cur.mask[k]}};
  end

  assign mem_re = rst_n && state == ACCESS && !err_q && (!cur.we || partial);
  assign mem_we = rst_n && ((state == ACCESS && !err_q && cur.we && full) || state == RMW_WR);
  assign mem_a  = (state == IDLE) ? 64'd0 : {cur.idx, 3'b000};
  assign mem_wd = (state == RMW_WR) ? merge_q : (mem_we ? cur.wdata : 64'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      last_owner <= 1'b1;
      merge_q    <= '0;
      rvalid     <= '0;
      wack       <= '0;
      err        <= '0;
      rdata      <= '0;
    end else begin
      rvalid <= '0;
      wack   <= '0;
      err    <= '0;
      case (state)
        IDLE: if (|req) begin
          cur.owner  <= win;
          cur.we     <= we[win];
          cur.idx    <= win ? addr1[63:3] : addr0[63:3];
          cur.wdata  <= win ? wdata1 : wdata0;
          cur.mask   <= win ? mask[15:8] : mask[7:0];
          last_owner <= win;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (!cur.we) begin
            rdata             <= err_q ? 64'd0 : mem_rd;
            rvalid[cur.owner] <= 1'b1;
            err[cur.owner]    <= err_q;
            state             <= IDLE;
          end else if (partial && !err_q) begin
            merge_q <= (mem_rd & ~bmask) | (cur.wdata & bmask);
            state   <= RMW_WR;
          end else begin
            // Full-mask write already landed this edge; empty or out-of-range stores just ack.
            wack[cur.owner] <= 1'b1;
            err[cur.owner]  <= err_q;
            state           <= IDLE;
          end
        end
        RMW_WR: begin
          wack[cur.owner] <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus random bench for dmem_arbiter; a word-array memory model and a
// reference copy of memory predict every grant, completion and stored word.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0, we = '0;
  logic [15:0] mask = '0;
  logic [63:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0]  gnt, rvalid, wack, err;
  logic [63:0] rdata, mem_a, mem_wd, mem_rd;
  logic        mem_we, mem_re;

  logic [63:0] mem [64];
  logic [63:0] ref_mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [63:0] pre_val = '0;
  int          errors = 0, checks = 0;
  int          last = 1;

  dmem_arbiter #(.DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .mask(mask),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt(gnt), .rvalid(rvalid), .wack(wack), .err(err), .rdata(rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = (mem_a[63:9] == '0) ? mem[mem_a[8:3]] : 64'd0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (mem_we && mem_a[63:9] == '0) mem[mem_a[8:3]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One single-requester access from grant to the idle cycle after completion.
  task automatic do_access(input int p, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] m);
    logic e, partial;
    int idx;
    logic [63:0] old, merged;
    e       = (a[63:3] >= 61'd64);
    idx     = e ? 0 : int'(a[8:3]);
    old     = e ? 64'd0 : ref_mem[idx];
    partial = w && m != 8'hFF && m != 8'h00;
    merged  = old;
    for (int k = 0; k < 8; k++) if (m[k]) merged[8*k +: 8] = d[8*k +: 8];
    req = '0; req[p] = 1'b1; we[p] = w; mask[p*8 +: 8] = m;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    #1 check("gnt", 64'(gnt), 64'(2'b01 << p));
    last = p;
    @(posedge clk); #1 req = '0;
    check("acc_re", 64'(mem_re), 64'(!e && (!w || partial)));
    check("acc_we", 64'(mem_we), 64'(!e && w && m == 8'hFF));
    check("acc_a", mem_a, {a[63:3], 3'b000});
    if (!e && w && m == 8'hFF) check("acc_wd", mem_wd, d);
    check("busy_pulse", 64'({rvalid, wack}), 64'd0);
    if (partial && !e) begin
      @(posedge clk); #1;
      check("rmw_we", 64'({mem_we, mem_re}), 64'(2'b10));
      check("rmw_wd", mem_wd, merged);
    end
    @(posedge clk); #1;
    if (!w) begin
      check("rvalid", 64'({rvalid, wack}), 64'({2'b01 << p, 2'b00}));
      check("rdata", rdata, old);
    end else begin
      check("wack", 64'({rvalid, wack}), 64'({2'b00, 2'b01 << p}));
    end
    check("err", 64'(err), e ? 64'(2'b01 << p) : 64'd0);
    if (!e && w) ref_mem[idx] = merged;
    if (!e) check("mem_word", mem[idx], ref_mem[idx]);
    @(posedge clk); #1;
    check("idle_outs", 64'({rvalid, wack, err, mem_we, mem_re}), 64'd0);
  endtask

  initial begin
    int prev, win;
    logic [63:0] v;
    // Preload memory while reset is held.
    for (int i = 0; i < 64; i++) begin
      v = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF :
          (i == 2) ? 64'hDEAD_BEEF_0000_0001 : {$urandom, $urandom};
      pre_we = 1'b1; pre_idx = 6'(i); pre_val = v; ref_mem[i] = v;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    req = 2'b11;
    #1 check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_outs", 64'({rvalid, wack, err, mem_we, mem_re}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    req = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both requesters hold loads: grants alternate, starting with requester 0.
    req = 2'b11; we = 2'b00; addr0 = 64'h10; addr1 = 64'h18; prev = -1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        win = 1 - last;
        check("tie_gnt", 64'(gnt), 64'(2'b01 << win));
        if (prev >= 0) begin
          check("tie_rvalid", 64'(rvalid), 64'(2'b01 << prev));
          check("tie_rdata", rdata, ref_mem[prev == 0 ? 2 : 3]);
        end
        prev = win; last = win;
      end else begin
        check("tie_busy_gnt", 64'(gnt), 64'd0);
        if (k == 7) req = 2'b00;
      end
      @(posedge clk);
    end
    #1 check("tie_rvalid", 64'(rvalid), 64'(2'b01 << prev));
    @(posedge clk); #1;

    do_access(0, 1'b0, 64'h10, 64'd0, 8'h00);
    check("load_const", rdata, 64'hDEAD_BEEF_0000_0001);
    do_access(1, 1'b1, 64'h08, 64'h1122_3344_5566_7788, 8'hFF);
    do_access(0, 1'b0, 64'h08, 64'd0, 8'h00);
    check("store_load_const", rdata, 64'h1122_3344_5566_7788);
    do_access(0, 1'b1, 64'h00, 64'd0, 8'h0F);
    check("rmw_const", mem[0], 64'hFFFF_FFFF_0000_0000);
    do_access(1, 1'b1, 64'h20, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00);
    do_access(0, 1'b0, 64'd512, 64'd0, 8'h00);
    do_access(0, 1'b1, 64'd512, 64'h0123_4567_89AB_CDEF, 8'hFF);
    do_access(1, 1'b1, 64'd520, 64'h0123_4567_89AB_CDEF, 8'h3C);

    // Reset lands in the write half of a read-modify-write.
    req = 2'b01; we = 2'b01; mask = 16'h00F0; addr0 = 64'h28; wdata0 = {$urandom, $urandom};
    #1 check("rr_gnt", 64'(gnt), 64'd1);
    @(posedge clk); #1 req = '0;
    check("rr_re", 64'(mem_re), 64'd1);
    @(posedge clk); #1 check("rr_we", 64'(mem_we), 64'd1);
    rst_n = 1'b0;
    #1 check("rr_we_drop", 64'({mem_we, mem_re}), 64'd0);
    @(posedge clk); #1 check("rr_no_ack", 64'({rvalid, wack, err}), 64'd0);
    rst_n = 1'b1; last = 1;
    @(posedge clk); #1 check("rr_no_ack2", 64'({rvalid, wack, err}), 64'd0);
    check("rr_mem", mem[5], ref_mem[5]);
    req = 2'b11; we = 2'b00; addr0 = 64'h10;
    #1 check("rr_gnt_after", 64'(gnt), 64'd1);
    last = 0;
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1 check("rr_rvalid", 64'(rvalid), 64'd1);
    check("rr_rdata", rdata, ref_mem[2]);
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      int p, r;
      logic [63:0] a;
      logic [7:0] m;
      p = $urandom_range(0, 1);
      r = $urandom_range(0, 3);
      m = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'($urandom);
      a = 64'($urandom_range(0, 71)) * 64'd8 + 64'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a[63] = 1'b1;
      do_access(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit; port 1 is the loader/debug port.
- Arbitrates round-robin and sequences each accepted access onto the memory's we/re/a/wd/rd interface.
- The memory writes whole doublewords only, so sub-doubleword stores run as read-modify-write.
- Sits between the requesters and the data memory; it is the only driver of the memory's control inputs.

Parameters:
- DEPTH, 64, number of 64-bit memory entries; valid index range is addr[63:3] < DEPTH.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  request, bit i = requester i; held with its fields until gnt[i]
- we  in  2  1 = store, 0 = load, per requester
- mask  in  16  byte enables; [7:0] requester 0, [15:8] requester 1; bit k = byte k; ignored for loads
- addr0  in  64  requester 0 byte address
- addr1  in  64  requester 1 byte address
- wdata0  in  64  requester 0 store data
- wdata1  in  64  requester 1 store data
- gnt  out  2  accept strobe, one cycle
- rvalid  out  2  load data valid, one cycle
- wack  out  2  store complete, one cycle
- err  out  2  out-of-range flag, coincident with rvalid/wack
- rdata  out  64  registered load data, valid when any rvalid bit is high
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_a  out  64  memory address, {addr[63:3],3'b000}
- mem_wd  out  64  memory write data
- mem_rd  in  64  memory read data, combinational from mem_a

Behaviour:
- Reset: clock and reset are fixed as clk and rst_n; reset is asynchronous, active-low.
  - Reset forces state IDLE and clears all outputs: gnt, rvalid, wack, err = 0; rdata = 0.
  - mem_we and mem_re are forced to 0 while rst_n is low; the pending transaction is dropped with no rvalid/wack.
  - last_owner resets to 1.
- States: IDLE, ACCESS, RMW_WR.
- Arbitration (IDLE only):
  - A single requester is granted.
  - If both request, the one not equal to last_owner wins, so requester 0 wins the first tie after reset.
  - gnt[w] is combinational and high in that IDLE cycle.
  - On the same edge: owner, we, addr, wdata, mask are captured into registers; last_owner <= w; state goes to ACCESS.
  - No gnt is issued outside IDLE.
- Range check: err_q = (addr_q[63:3] >= DEPTH). If err_q is set:
  - ACCESS drives no mem_re/mem_we.
  - A load completes with rdata = 0 and err.
  - A store completes with wack and err, and memory is unchanged.
- ACCESS, load:
  - mem_re = 1.
  - At the edge: rdata <= mem_rd, rvalid[owner] <= 1, state goes to IDLE.
- ACCESS, store with mask = 8'hFF:
  - mem_we = 1 and mem_wd = wdata_q; the write lands at this edge.
  - wack[owner] <= 1, state goes to IDLE.
- ACCESS, store with mask = 8'h00: no memory activity, wack[owner] <= 1, state goes to IDLE.
- ACCESS, partial store (other masks):
  - mem_re = 1.
  - merge_q <= (mem_rd & ~M) | (wdata_q & M), where M expands each mask bit to 8 bits.
  - State goes to RMW_WR.
- RMW_WR: mem_we = 1 and mem_wd = merge_q; at the edge wack[owner] <= 1 and state goes to IDLE.
- Latency, with the grant in cycle T:
  - load: rvalid in T+2
  - full or empty-mask store: wack in T+2, write lands on the T+1→T+2 edge
  - partial store: wack in T+3
  - Completion cycle is an IDLE cycle, so a new grant can coincide with rvalid/wack.
- Memory outputs:
  - mem_a = {addr_q[63:3],3'b000} in ACCESS/RMW_WR; 0 in IDLE.
  - mem_we and mem_re are never both 1 in the same cycle.
  - rdata holds its value until the next load completes.
- rvalid, wack, err are single-cycle pulses, registered, cleared the cycle after being set.

Test Plan:
- Reset, then req=2'b01, we=0, addr0=0x10 with entry 2 = 0xDEAD_BEEF_0000_0001 → gnt=01 in cycle 0; mem_re in cycle 1; rvalid=01 and rdata=0xDEADBEEF00000001 in cycle 2.
- Both requesters hold req=2'b11 (loads) continuously → grants alternate 01,10,01,10 on every IDLE cycle; first grant after reset is to 0.
- Requester 1 stores wdata1=0x1122334455667788 with mask=8'hFF to addr1=0x08 → mem_we one cycle, wack=10 at T+2; a later load of 0x08 returns 0x1122334455667788.
- Entry 0 = 0xFFFF_FFFF_FFFF_FFFF; requester 0 stores wdata0=0, mask 8'h0F → mem_re then mem_we, wack at T+3; entry reads 0xFFFFFFFF00000000.
- Load from addr0=64*8 (index 64, DEPTH=64) → no mem_re, rvalid=01 with err=01 and rdata=0; a store to the same address gives wack and err with memory untouched.
- Assert rst_n low during RMW_WR of a partial store → mem_we drops immediately, no wack, memory word unchanged, and the next grant goes to requester 0.
